// File: rtl/gate_classifier_if.sv
// Probe-side bundle of gate_classifier: run request, probe drive/return
// from the gate under test, and the classification result.
interface gate_classifier_if;
   logic       start;
   logic       probe_a;
   logic       probe_b;
   logic       probe_y;
   logic       busy;
   logic       done;
   logic [3:0] tt;
   logic [2:0] gate_id;
   logic       unstable;

   modport master (
      output start, probe_y,
      input  probe_a, probe_b, busy, done, tt, gate_id, unstable
   );

   modport slave (
      input  start, probe_y,
      output probe_a, probe_b, busy, done, tt, gate_id, unstable
   );
endinterface

// File: rtl/gate_classifier.sv
// Sweeps the four input vectors onto an unknown 2-input gate, builds its truth
// table and decodes the gate. GATE_CLASSIFIER_CHECK_EN adds a second verifying sweep.
//
// state  | meaning
// IDLE   | waiting for start, probes at 0, results held
// DRIVE  | probe vector idx held for SETTLE cycles, sampled on the last one
// FINISH | one cycle: done pulse, new results visible, start accepted
module gate_classifier #(
   parameter int SETTLE = 1
) (
   input  logic          clk,
   input  logic          rst,
   gate_classifier_if.slave bus
);
   localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FINISH} state_t;

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    scr_q, scr_d;
   logic [3:0]    tt_q, tt_d;
   logic [2:0]    gid_q, gid_d;
   logic [3:0]    scr_cap;
   logic          last_pass;
`ifdef GATE_CLASSIFIER_CHECK_EN
   logic          pass_q, pass_d;
   logic [3:0]    first_q, first_d;
   logic          unstable_q, unstable_d;
`endif

   function automatic logic [2:0] decode(input logic [3:0] t);
      case (t)
         4'b1000: decode = 3'd0;
         4'b1110: decode = 3'd1;
         4'b0111: decode = 3'd2;
         4'b0001: decode = 3'd3;
         4'b0110: decode = 3'd4;
         4'b1001: decode = 3'd5;
         4'b0011: decode = 3'd6;
         default: decode = 3'd7;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      scr_d   = scr_q;
      tt_d    = tt_q;
      gid_d   = gid_q;
      scr_cap = scr_q;
      scr_cap[idx_q] = bus.probe_y;
`ifdef GATE_CLASSIFIER_CHECK_EN
      pass_d     = pass_q;
      first_d    = first_q;
      unstable_d = unstable_q;
      last_pass  = pass_q;
`else
      last_pass  = 1'b1;
`endif
      case (state_q)
         S_IDLE, S_FINISH: begin
            state_d = S_IDLE;
            if (bus.start) begin
               state_d = S_DRIVE;
               idx_d   = 2'd0;
               cnt_d   = CNT_LOAD;
`ifdef GATE_CLASSIFIER_CHECK_EN
               pass_d  = 1'b0;
`endif
            end
         end
         S_DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               scr_d = scr_cap;
               cnt_d = CNT_LOAD;
               if (idx_q != 2'd3) begin
                  idx_d = idx_q + 2'd1;
               end else if (!last_pass) begin
`ifdef GATE_CLASSIFIER_CHECK_EN
                  pass_d  = 1'b1;
                  first_d = scr_cap;
`endif
                  idx_d   = 2'd0;
               end else begin
                  // results are loaded as FINISH is entered so they appear with done
                  state_d = S_FINISH;
                  tt_d    = scr_cap;
`ifdef GATE_CLASSIFIER_CHECK_EN
                  unstable_d = (scr_cap != first_q);
                  gid_d      = (scr_cap != first_q) ? 3'd7 : decode(scr_cap);
`else
                  gid_d      = decode(scr_cap);
`endif
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         scr_q   <= 4'b0000;
         tt_q    <= 4'b0000;
         gid_q   <= 3'd7;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         scr_q   <= scr_d;
         tt_q    <= tt_d;
         gid_q   <= gid_d;
      end
   end

`ifdef GATE_CLASSIFIER_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_q     <= 1'b0;
         first_q    <= 4'b0000;
         unstable_q <= 1'b0;
      end else begin
         pass_q     <= pass_d;
         first_q    <= first_d;
         unstable_q <= unstable_d;
      end
   end
   assign bus.unstable = unstable_q;
`else
   assign bus.unstable = 1'b0;
`endif

   assign bus.busy    = (state_q == S_DRIVE);
   assign bus.done    = (state_q == S_FINISH);
   assign bus.probe_a = (state_q == S_DRIVE) ? idx_q[1] : 1'b0;
   assign bus.probe_b = (state_q == S_DRIVE) ? idx_q[0] : 1'b0;
   assign bus.tt      = tt_q;
   assign bus.gate_id = gid_q;
endmodule

// File: tb/tb_gate_classifier.sv
// Self-checking bench for gate_classifier: two instances (SETTLE=1 and SETTLE=3)
// probing modelled gates; honours GATE_CLASSIFIER_CHECK_EN when defined.
module tb_gate_classifier;
`ifdef GATE_CLASSIFIER_CHECK_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   logic start;
   bit   sel;
   logic [3:0] model1, model3;
   int checks = 0;
   int failures = 0;
   logic [3:0] prev_tt [2];
   logic [2:0] prev_id [2];

   gate_classifier_if if1();
   gate_classifier_if if3();

   gate_classifier #(.SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
   gate_classifier #(.SETTLE(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

   assign if1.start   = start & ~sel;
   assign if3.start   = start & sel;
   assign if1.probe_y = model1[{if1.probe_a, if1.probe_b}];
   assign if3.probe_y = model3[{if3.probe_a, if3.probe_b}];

   wire       busy_m = sel ? if3.busy : if1.busy;
   wire       done_m = sel ? if3.done : if1.done;
   wire [1:0] prb_m  = sel ? {if3.probe_a, if3.probe_b} : {if1.probe_a, if1.probe_b};
   wire [3:0] tt_m   = sel ? if3.tt : if1.tt;
   wire [2:0] id_m   = sel ? if3.gate_id : if1.gate_id;
   wire       uns_m  = sel ? if3.unstable : if1.unstable;

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // gate behaviour written directly as boolean expressions; 7 = constant 1
   function automatic logic gate_eval(input int g, input logic a, input logic b);
      case (g)
         0: gate_eval = a & b;
         1: gate_eval = a | b;
         2: gate_eval = ~(a & b);
         3: gate_eval = ~(a | b);
         4: gate_eval = a ^ b;
         5: gate_eval = ~(a ^ b);
         6: gate_eval = ~a;
         default: gate_eval = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] build_tt(input int g);
      logic [3:0] t;
      logic [1:0] ab;
      for (int i = 0; i < 4; i++) begin
         ab = 2'(i);
         t[i] = gate_eval(g, ab[1], ab[0]);
      end
      return t;
   endfunction

   function automatic logic [2:0] ref_id(input logic [3:0] t);
      logic [2:0] id = 3'd7;
      for (int g = 0; g < 7; g++)
         if (build_tt(g) == t) id = 3'(g);
      return id;
   endfunction

   task automatic set_model(input logic [3:0] m);
      if (sel) model3 = m; else model1 = m;
   endtask

   task automatic run(input bit s, input logic [3:0] m, input logic [3:0] exp_tt,
                      input logic [2:0] exp_id, input logic exp_uns, input bit mid_pulse,
                      input bit b2b, input bit swap2, input logic [3:0] m2);
      int st, n;
      bit bad_busy, bad_probe, bad_hold;
      sel = s;
      st = s ? 3 : 1;
      n = PASSES * 4 * st;
      chk("idle_before_start", {31'd0, busy_m}, 0);
      set_model(m);
      start = 1'b1;
      step();
      start = 1'b0;
      bad_busy = 0; bad_probe = 0; bad_hold = 0;
      for (int k = 0; k < n; k++) begin
         if (busy_m !== 1'b1 || done_m !== 1'b0) bad_busy = 1;
         if (prb_m !== 2'((k / st) % 4)) bad_probe = 1;
         if (tt_m !== prev_tt[s] || id_m !== prev_id[s]) bad_hold = 1;
         if (mid_pulse) start = (k == 1 || k == 2);
         if (swap2 && k == 4 * st) set_model(m2);
         step();
      end
      start = 1'b0;
      chk("busy_during_run", {31'd0, bad_busy}, 0);
      chk("probe_sequence", {31'd0, bad_probe}, 0);
      chk("results_held", {31'd0, bad_hold}, 0);
      chk("done_pulse", {31'd0, done_m}, 1);
      chk("busy_low_at_done", {31'd0, busy_m}, 0);
      chk("probes_zero_at_done", {30'd0, prb_m}, 0);
      chk("tt", {28'd0, tt_m}, {28'd0, exp_tt});
      chk("gate_id", {29'd0, id_m}, {29'd0, exp_id});
      chk("unstable", {31'd0, uns_m}, {31'd0, exp_uns});
      prev_tt[s] = exp_tt;
      prev_id[s] = exp_id;
      if (b2b) begin
         start = 1'b1;
      end else begin
         step();
         chk("done_single_cycle", {30'd0, done_m, busy_m}, 0);
      end
   endtask

   typedef struct {
      int         kind;
      logic [3:0] exp_tt;
      logic [2:0] exp_id;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{0, 4'b1000, 3'd0};
      vecs[1] = '{1, 4'b1110, 3'd1};
      vecs[2] = '{2, 4'b0111, 3'd2};
      vecs[3] = '{3, 4'b0001, 3'd3};
      vecs[4] = '{4, 4'b0110, 3'd4};
      vecs[5] = '{5, 4'b1001, 3'd5};
      vecs[6] = '{6, 4'b0011, 3'd6};
      vecs[7] = '{7, 4'b1111, 3'd7};

      rst = 1'b1; start = 1'b0; sel = 0;
      model1 = 4'b0000; model3 = 4'b0000;
      prev_tt[0] = 4'b0000; prev_tt[1] = 4'b0000;
      prev_id[0] = 3'd7; prev_id[1] = 3'd7;
      step();
      step();
      for (int d = 0; d < 2; d++) begin
         sel = d[0];
         chk("reset_outputs", {22'd0, busy_m, done_m, prb_m, tt_m, id_m, uns_m},
             {22'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'd7, 1'b0});
      end
      rst = 1'b0;
      step();

      // every supported gate plus constant 1, on both settle lengths
      foreach (vecs[i])
         for (int d = 0; d < 2; d++)
            run(d[0], build_tt(vecs[i].kind), vecs[i].exp_tt, vecs[i].exp_id,
                1'b0, 0, 0, 0, 4'b0000);

      // NOR run with stray starts mid-run, then a start on the done cycle
      run(0, build_tt(3), 4'b0001, 3'd3, 1'b0, 1, 1, 0, 4'b0000);
      run(0, build_tt(3), 4'b0001, 3'd3, 1'b0, 0, 0, 0, 4'b0000);

      // reset mid-run after an OR result
      run(0, build_tt(1), 4'b1110, 3'd1, 1'b0, 0, 0, 0, 4'b0000);
      sel = 0;
      model1 = build_tt(0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("reset_midrun", {22'd0, busy_m, done_m, prb_m, tt_m, id_m, uns_m},
          {22'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'd7, 1'b0});
      prev_tt[0] = 4'b0000; prev_tt[1] = 4'b0000;
      prev_id[0] = 3'd7; prev_id[1] = 3'd7;
      step();
      rst = 1'b0;
      begin
         bit saw_done = 0;
         for (int k = 0; k < 8; k++) begin
            if (done_m !== 1'b0 || busy_m !== 1'b0) saw_done = 1;
            step();
         end
         chk("no_done_after_reset", {31'd0, saw_done}, 0);
      end
      run(0, build_tt(0), 4'b1000, 3'd0, 1'b0, 0, 0, 0, 4'b0000);

`ifdef GATE_CLASSIFIER_CHECK_EN
      run(0, build_tt(2), 4'b0111, 3'd2, 1'b0, 0, 0, 0, 4'b0000);
      run(0, build_tt(0), 4'b1110, 3'd7, 1'b1, 0, 0, 1, build_tt(1));
      run(1, build_tt(4), 4'b0110, 3'd4, 1'b0, 0, 0, 0, 4'b0000);
`endif

      // random truth tables against the boolean reference
      for (int r = 0; r < 24; r++) begin
         logic [3:0] m;
         bit s;
         m = 4'($urandom);
         s = 1'($urandom_range(0, 1));
         run(s, m, m, ref_id(m), 1'b0, 0, 0, 0, 4'b0000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
